dot_acc_engine: RTL and testbench



---
 rtl/dot_acc_pkg.sv | 21 ++
 rtl/dot_adder_tree.sv | 58 +++++
 rtl/dot_acc_engine.sv | 85 ++++++++
 tb/tb_dot_acc_engine.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dot_acc_pkg.sv
// dot_acc_pkg: shared helpers, wide arithmetic type and frame FSM encoding for the dot-product engine
package dot_acc_pkg;
  localparam int MAX_W = 128;
  typedef logic signed [MAX_W-1:0] wide_t;
  typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} state_e;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic wide_t sat_s(input wide_t v, input int w);
    wide_t hi, lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    return v > hi ? hi : (v < lo ? lo : v);
  endfunction
  function automatic wide_t rnd_const(input int frac);
    return frac > 0 ? wide_t'(1) <<< (frac - 1) : wide_t'(0);
  endfunction
endpackage

// File: rtl/dot_adder_tree.sv
// dot_adder_tree: registered binary reduction of N signed lanes with a matching sideband delay line
module dot_adder_tree
  import dot_acc_pkg::*;
#(
  parameter int N = 4,
  parameter int IN_W = 32,
  localparam int L = clog2(N),
  localparam int OUT_W = IN_W + L
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [N*IN_W-1:0]       din,
  output logic                    out_valid,
  output logic                    out_first,
  output logic                    out_last,
  output logic signed [OUT_W-1:0] sum
);
  logic signed [OUT_W-1:0] lvl0 [N];
  always_comb begin
    for (int j = 0; j < N; j++) lvl0[j] = OUT_W'($signed(din[j*IN_W +: IN_W]));
  end
  if (L == 0) begin : g_pass
    assign sum = lvl0[0];
    assign out_valid = in_valid;
    assign out_first = in_first;
    assign out_last = in_last;
  end else begin : g_tree
    logic signed [OUT_W-1:0] prev [L][N];
    logic signed [OUT_W-1:0] node_d [L][N];
    logic signed [OUT_W-1:0] node_q [L][N];
    logic [2:0] sb_d [L];
    logic [2:0] sb_q [L];
    function automatic int cnt(input int l);
      return (N + (1 << l) - 1) >> l;
    endfunction
    // nodes are kept at full output width; an odd leftover adds zero and so passes through
    always_comb begin
      for (int j = 0; j < N; j++) prev[0][j] = lvl0[j];
      for (int l = 1; l < L; l++)
        for (int j = 0; j < N; j++) prev[l][j] = node_q[l-1][j];
      for (int l = 0; l < L; l++)
        for (int j = 0; j < N; j++)
          node_d[l][j] = (2*j < cnt(l) ? prev[l][2*j < N ? 2*j : 0] : '0)
                       + (2*j + 1 < cnt(l) ? prev[l][2*j + 1 < N ? 2*j + 1 : 0] : '0);
      sb_d[0] = {in_valid, in_valid & in_first, in_valid & in_last};
      for (int l = 1; l < L; l++) sb_d[l] = sb_q[l-1];
    end
    always_ff @(posedge clk) begin
      node_q <= node_d;
      for (int l = 0; l < L; l++) sb_q[l] <= rst ? 3'b000 : sb_d[l];
    end
    assign sum = node_q[L-1][0];
    assign {out_valid, out_first, out_last} = sb_q[L-1];
  end
endmodule

// File: rtl/dot_acc_engine.sv
// dot_acc_engine: K-lane fixed-point dot product with multi-beat accumulation, rounding and saturation
module dot_acc_engine
  import dot_acc_pkg::*;
#(
  parameter int K = 4,
  parameter int WIDTH = 16,
  parameter int FRAC = 8,
  parameter int ACC_W = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic               in_last,
  input  logic [K*WIDTH-1:0] A,
  input  logic [K*WIDTH-1:0] B,
  output logic               out_valid,
  output logic [WIDTH-1:0]   Y,
  output logic               out_ovf,
  output logic               protocol_err
);
  localparam int L = clog2(K);
  localparam int PW = 2 * WIDTH;
  localparam int TW = PW + L;
  if (ACC_W < TW || ACC_W > MAX_W - 2) begin : g_bad_acc
    $error("dot_acc_engine: ACC_W=%0d outside [%0d, %0d]", ACC_W, TW, MAX_W - 2);
  end
  state_e state_q, state_d;
  logic [K*PW-1:0] prod_q, prod_d;
  logic m_valid_q, m_first_q, m_last_q, m_valid_d, m_first_d, m_last_d;
  logic first_eff, err_q, err_d;
  logic t_valid, t_first, t_last;
  logic signed [TW-1:0] t_sum;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic ovf_acc_q, ovf_acc_d, last_q, last_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic out_ovf_q, out_ovf_d, out_valid_q, out_valid_d;
  wide_t acc_sum, acc_sat, r, y_sat;
  dot_adder_tree #(.N(K), .IN_W(PW)) u_tree (
    .clk(clk), .rst(rst),
    .in_valid(m_valid_q), .in_first(m_first_q), .in_last(m_last_q), .din(prod_q),
    .out_valid(t_valid), .out_first(t_first), .out_last(t_last), .sum(t_sum)
  );
  // framing is resolved at the input so the pipeline only carries an effective first
  always_comb begin
    for (int n = 0; n < K; n++)
      prod_d[n*PW +: PW] = PW'($signed(A[n*WIDTH +: WIDTH]) * $signed(B[n*WIDTH +: WIDTH]));
    first_eff = in_first || state_q == IDLE;
    err_d = in_valid && (in_first == (state_q == OPEN));
    state_d = in_valid ? (in_last ? IDLE : OPEN) : state_q;
    m_valid_d = in_valid;
    m_first_d = in_valid & first_eff;
    m_last_d = in_valid & in_last;
    acc_sum = wide_t'(acc_q) + wide_t'(t_sum);
    acc_sat = sat_s(acc_sum, ACC_W);
    acc_d = !t_valid ? acc_q : (t_first ? ACC_W'(t_sum) : ACC_W'(acc_sat));
    ovf_acc_d = !t_valid ? ovf_acc_q : (t_first ? 1'b0 : ovf_acc_q | (acc_sat != acc_sum));
    last_d = t_valid & t_last;
    r = (wide_t'(acc_q) + rnd_const(FRAC)) >>> FRAC;
    y_sat = sat_s(r, WIDTH);
    y_d = last_q ? WIDTH'(y_sat) : y_q;
    out_ovf_d = last_q ? ovf_acc_q | (y_sat != r) : out_ovf_q;
    out_valid_d = last_q;
  end
  always_ff @(posedge clk) begin
    prod_q <= prod_d;
    if (rst) begin
      state_q <= IDLE;
      {m_valid_q, m_first_q, m_last_q, err_q} <= '0;
      acc_q <= '0;
      {ovf_acc_q, last_q, out_ovf_q, out_valid_q} <= '0;
      y_q <= '0;
    end else begin
      state_q <= state_d;
      {m_valid_q, m_first_q, m_last_q, err_q} <= {m_valid_d, m_first_d, m_last_d, err_d};
      acc_q <= acc_d;
      {ovf_acc_q, last_q, out_ovf_q, out_valid_q} <= {ovf_acc_d, last_d, out_ovf_d, out_valid_d};
      y_q <= y_d;
    end
  end
  assign out_valid = out_valid_q;
  assign Y = y_q;
  assign out_ovf = out_ovf_q;
  assign protocol_err = err_q;
endmodule

// File: tb/tb_dot_acc_engine.sv
// tb_dot_acc_engine: directed and randomized checks of dot_acc_engine against a frame-level model
module tb_dot_acc_engine;
  localparam int K = 4, W = 16, LAT = 5, NEXP = 4096;
  localparam longint ACC_MAX = (64'sd1 <<< 39) - 1;
  logic clk = 0, rst = 1, in_valid = 0, in_first = 0, in_last = 0;
  logic [K*W-1:0] A = '0, B = '0;
  logic out_valid, out_ovf, protocol_err;
  logic [W-1:0] Y;
  int cyc = 0, checks = 0, errors = 0, last_drive = 0;
  bit exp_v [NEXP];
  bit exp_o [NEXP];
  bit exp_e [NEXP];
  int exp_y [NEXP];
  bit open_m = 0, ovf_m = 0, model_o = 0;
  longint acc_m = 0;
  int model_y = 0;
  logic [K*W-1:0] all128, all256, bpat, v1, v2;

  dot_acc_engine #(.K(K), .WIDTH(W), .FRAC(8), .ACC_W(40)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .A(A), .B(B), .out_valid(out_valid), .Y(Y), .out_ovf(out_ovf), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [K*W-1:0] pk(input int l3, input int l2, input int l1, input int l0);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  function automatic logic [K*W-1:0] rnd_vec();
    logic [K*W-1:0] v;
    for (int n = 0; n < K; n++)
      v[n*W +: W] = $urandom_range(0, 9) == 0 ? ($urandom_range(0, 1) ? 16'h7FFF : 16'h8000)
                                                : 16'($urandom_range(0, 4095) - 2048);
    return v;
  endfunction

  task automatic model_beat(input bit f, input bit l, input logic [K*W-1:0] a, input logic [K*W-1:0] b);
    longint dot, s, rr;
    bit err, clamp;
    dot = 0;
    for (int n = 0; n < K; n++) dot += longint'($signed(a[n*W +: W])) * longint'($signed(b[n*W +: W]));
    err = (f == open_m);
    if (f || !open_m) begin
      acc_m = dot;
      ovf_m = 0;
    end else begin
      s = acc_m + dot;
      if (s > ACC_MAX) begin s = ACC_MAX; ovf_m = 1; end
      else if (s < -ACC_MAX - 1) begin s = -ACC_MAX - 1; ovf_m = 1; end
      acc_m = s;
    end
    open_m = !l;
    if (err && cyc + 1 < NEXP) exp_e[cyc + 1] = 1;
    if (l) begin
      rr = (acc_m + 128) >>> 8;
      clamp = rr > 32767 || rr < -32768;
      model_y = clamp ? (rr > 0 ? 32767 : -32768) : int'(rr);
      model_o = ovf_m | clamp;
      if (cyc + LAT < NEXP) begin
        exp_v[cyc + LAT] = 1;
        exp_y[cyc + LAT] = model_y;
        exp_o[cyc + LAT] = model_o;
      end
    end
  endtask

  task automatic beat(input bit f, input bit l, input logic [K*W-1:0] a, input logic [K*W-1:0] b);
    @(posedge clk); #1;
    in_valid = 1; in_first = f; in_last = l; A = a; B = b;
    model_beat(f, l, a, b);
    last_drive = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 0; in_first = 1'($urandom); in_last = 1'($urandom);
      A = {$urandom, $urandom}; B = {$urandom, $urandom};
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    in_valid = 0; rst = 1;
    for (int c = cyc + 1; c < NEXP; c++) begin exp_v[c] = 0; exp_e[c] = 0; end
    open_m = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic expect_frame(input string name, input int want_y, input bit want_o);
    int tgt;
    tgt = last_drive + LAT;
    checks++;
    if (model_y != want_y || model_o != want_o) begin
      errors++;
      $display("FAIL model_%s: model y=%0d ovf=%0d, hand value y=%0d ovf=%0d", name, model_y, model_o, want_y, want_o);
    end
    idle(1);
    while (cyc < tgt) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || int'($signed(Y)) != want_y || out_ovf !== want_o) begin
      errors++;
      $display("FAIL %s at cyc %0d: out_valid=%b Y=%0d ovf=%b, expected 1 %0d %0d", name, cyc, out_valid, $signed(Y), out_ovf, want_y, want_o);
    end
  endtask

  task automatic expect_err_model(input string name);
    checks++;
    if (!exp_e[last_drive + 1]) begin
      errors++;
      $display("FAIL model_%s: model predicts no protocol_err, expected a pulse", name);
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < NEXP) begin
      checks++;
      if (out_valid !== exp_v[cyc]) begin
        errors++;
        $display("FAIL out_valid cyc %0d: got %b expected %b", cyc, out_valid, exp_v[cyc]);
      end
      checks++;
      if (protocol_err !== exp_e[cyc]) begin
        errors++;
        $display("FAIL protocol_err cyc %0d: got %b expected %b", cyc, protocol_err, exp_e[cyc]);
      end
      if (exp_v[cyc]) begin
        checks++;
        if (int'($signed(Y)) != exp_y[cyc] || out_ovf !== exp_o[cyc]) begin
          errors++;
          $display("FAIL result cyc %0d: Y=%0d ovf=%b expected Y=%0d ovf=%0d", cyc, $signed(Y), out_ovf, exp_y[cyc], exp_o[cyc]);
        end
      end
    end
  end

  initial begin
    all128 = pk(128, 128, 128, 128);
    all256 = pk(256, 256, 256, 256);
    bpat = pk(1024, 768, 512, 256);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    idle(2);
    beat(1, 1, all256, bpat);
    expect_frame("single", 2560, 0);
    beat(1, 0, all128, all128); beat(0, 0, all128, all128); beat(0, 1, all128, all128);
    expect_frame("three_beat", 768, 0);
    beat(1, 0, all128, all128); idle(1); beat(0, 0, all128, all128); beat(0, 1, all128, all128);
    expect_frame("three_beat_gap", 768, 0);
    beat(1, 1, pk(0, 0, 0, 1), pk(0, 0, 0, 128));
    expect_frame("round_pos", 1, 0);
    beat(1, 1, pk(0, 0, 0, -1), pk(0, 0, 0, 128));
    expect_frame("round_half_neg", 0, 0);
    beat(1, 1, pk(0, 0, 0, -1), pk(0, 0, 0, 384));
    expect_frame("round_neg", -1, 0);
    beat(1, 1, pk(32767, 32767, 32767, 32767), pk(32767, 32767, 32767, 32767));
    expect_frame("sat_pos", 32767, 1);
    beat(1, 1, pk(-32768, -32768, -32768, -32768), pk(32767, 32767, 32767, 32767));
    expect_frame("sat_neg", -32768, 1);
    beat(1, 1, all256, bpat);
    expect_frame("clean_after_sat", 2560, 0);
    beat(0, 1, all256, all256);
    expect_err_model("implicit_first");
    expect_frame("implicit_first", 1024, 0);
    beat(1, 0, all128, all128);
    beat(1, 1, all256, bpat);
    expect_err_model("restart");
    expect_frame("restart", 2560, 0);
    beat(1, 0, all128, all128); beat(0, 0, all128, all128);
    pulse_reset();
    beat(1, 1, all256, bpat);
    expect_frame("after_reset", 2560, 0);
    for (int i = 0; i < 20; i++) begin
      v1 = rnd_vec(); v2 = rnd_vec();
      beat(1, 1, v1, v2);
    end
    idle(8);
    for (int i = 0; i < 400 && cyc < NEXP - 40; i++) begin
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
      else begin
        v1 = rnd_vec(); v2 = rnd_vec();
        beat($urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, v1, v2);
      end
      if (i == 200) pulse_reset();
    end
    idle(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
